// File: rtl/seq_mcycle_gen.sv
// Machine-cycle generator: splits instructions into M-cycles of T-states
// and decodes the per-T-state strobes from registered state.
module seq_mcycle_gen #(
   parameter int T_PER_M    = 4,
   parameter int MCYC_W     = 3,
   parameter int WAIT_T     = 1,
   parameter int MREQ_FIRST = 0,
   parameter int MREQ_LAST  = 2,
   localparam int TW = ($clog2(T_PER_M) < 1) ? 1 : $clog2(T_PER_M)
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic [MCYC_W-1:0] mcyc_len,
   input  logic              mem_en,
   input  logic              wait_n,
   input  logic              halt,
   input  logic              wake,
   output logic [TW-1:0]     tstate,
   output logic [MCYC_W-1:0] mcyc,
   output logic              busy,
   output logic              mreq_n,
   output logic              ld_strobe,
   output logic              mcyc_done,
   output logic              seq_done,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STALL,
      S_HALT
   } state_t;

   localparam logic [TW-1:0]     T_LAST = TW'(T_PER_M - 1);
   localparam logic [TW-1:0]     T_WAIT = TW'(WAIT_T);
   localparam logic [MCYC_W-1:0] M_ONE  = MCYC_W'(1);

   state_t              state;
   logic [MCYC_W-1:0]   len_q;
   logic                mem_en_q;
   logic [MCYC_W-1:0]   len_in;
   logic                last_m;

   // A zero length request still runs a single M-cycle
   assign len_in = (mcyc_len == '0) ? M_ONE : mcyc_len;
   assign last_m = (mcyc == len_q - M_ONE);

   always_ff @(posedge clk) begin
      if (res) begin
         state    <= S_IDLE;
         tstate   <= '0;
         mcyc     <= '0;
         len_q    <= M_ONE;
         mem_en_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_RUN;
                  tstate   <= '0;
                  mcyc     <= '0;
                  len_q    <= len_in;
                  mem_en_q <= mem_en;
               end
            end
            S_RUN: begin
               if (tstate == T_WAIT && !wait_n) begin
                  state <= S_STALL;
               end else if (tstate == T_LAST) begin
                  tstate   <= '0;
                  mem_en_q <= mem_en;
                  if (!last_m) begin
                     mcyc <= mcyc + M_ONE;
                  end else begin
                     mcyc <= '0;
                     if (halt) begin
                        state <= S_HALT;
                     end else if (start) begin
                        len_q <= len_in;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end else begin
                  tstate <= tstate + TW'(1);
               end
            end
            S_STALL: begin
               if (wait_n) begin
                  state  <= S_RUN;
                  tstate <= tstate + TW'(1);
               end
            end
            S_HALT: begin
               if (wake) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state == S_RUN) || (state == S_STALL);
   assign halted    = (state == S_HALT);
   assign mcyc_done = (state == S_RUN) && (tstate == T_LAST);
   assign ld_strobe = mcyc_done;
   assign seq_done  = mcyc_done && last_m;
   assign mreq_n    = !(busy && mem_en_q &&
                        (int'(tstate) >= MREQ_FIRST) &&
                        (int'(tstate) <= MREQ_LAST));

endmodule

// File: tb/tb_seq_mcycle_gen.sv
// Directed bench for seq_mcycle_gen: default instance plus a
// T_PER_M=3 / MCYC_W=2 instance for the parameter sweep.
module tb_seq_mcycle_gen;

   logic       clk = 1'b0;
   logic       res, start, mem_en, wait_n, halt, wake;
   logic [2:0] mcyc_len;
   logic [1:0] tstate;
   logic [2:0] mcyc;
   logic       busy, mreq_n, ld_strobe, mcyc_done, seq_done, halted;

   logic       start2;
   logic [1:0] mcyc_len2;
   logic [1:0] tstate2;
   logic [1:0] mcyc2;
   logic       busy2, mreq_n2, ld2, mdone2, sdone2, halted2;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   seq_mcycle_gen dut (
      .clk(clk), .res(res), .start(start), .mcyc_len(mcyc_len),
      .mem_en(mem_en), .wait_n(wait_n), .halt(halt), .wake(wake),
      .tstate(tstate), .mcyc(mcyc), .busy(busy), .mreq_n(mreq_n),
      .ld_strobe(ld_strobe), .mcyc_done(mcyc_done),
      .seq_done(seq_done), .halted(halted)
   );

   seq_mcycle_gen #(.T_PER_M(3), .MCYC_W(2)) dut2 (
      .clk(clk), .res(res), .start(start2), .mcyc_len(mcyc_len2),
      .mem_en(mem_en), .wait_n(wait_n), .halt(halt), .wake(wake),
      .tstate(tstate2), .mcyc(mcyc2), .busy(busy2), .mreq_n(mreq_n2),
      .ld_strobe(ld2), .mcyc_done(mdone2),
      .seq_done(sdone2), .halted(halted2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // {busy,tstate,mcyc,mreq_n,ld_strobe,mcyc_done,seq_done,halted}
   function automatic logic [10:0] obs();
      return {busy, tstate, mcyc, mreq_n, ld_strobe,
              mcyc_done, seq_done, halted};
   endfunction

   function automatic logic [10:0] exp_v(logic b, logic [1:0] t,
      logic [2:0] m, logic rq, logic ld, logic sd, logic h);
      return {b, t, m, rq, ld, ld, sd, h};
   endfunction

   task automatic test_reset;
      logic [10:0] e;
      res      = 1'b1;
      start    = 1'($urandom);
      mcyc_len = 3'($urandom);
      mem_en   = 1'($urandom);
      wait_n   = 1'($urandom);
      halt     = 1'($urandom);
      wake     = 1'($urandom);
      start2   = 1'($urandom);
      mcyc_len2 = 2'($urandom);
      tick();
      tick();
      e = exp_v(0, 0, 0, 1, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL reset: got %b want %b", obs(), e);
      end
      vecs++;
      if ({busy2, tstate2, mcyc2, mreq_n2, ld2, sdone2, halted2}
          !== 9'b0_00_00_1_0_0_0) begin
         errs++;
         $display("FAIL reset2: got %b want 000001000",
            {busy2, tstate2, mcyc2, mreq_n2, ld2, sdone2, halted2});
      end
      res = 1'b0; start = 1'b0; mcyc_len = 3'd0; mem_en = 1'b0;
      wait_n = 1'b1; halt = 1'b0; wake = 1'b0;
      start2 = 1'b0; mcyc_len2 = 2'd0;
      tick();
   endtask

   task automatic test_two_mcyc;
      logic [10:0] e;
      logic [1:0]  t;
      start = 1'b1; mcyc_len = 3'd2; mem_en = 1'b1; wait_n = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         t = 2'((c - 1) % 4);
         e = exp_v(1, t, 3'((c - 1) / 4), (t == 2'd3),
                   (t == 2'd3), (c == 8), 0);
         vecs++;
         if (obs() !== e) begin
            errs++;
            $display("FAIL two_mcyc c%0d: got %b want %b", c, obs(), e);
         end
         tick();
      end
      e = exp_v(0, 0, 0, 1, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL two_mcyc idle: got %b want %b", obs(), e);
      end
   endtask

   task automatic test_wait;
      logic [10:0] e;
      start = 1'b1; mcyc_len = 3'd1; mem_en = 1'b1;
      tick();
      start = 1'b0;
      tick();
      wait_n = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         if (c == 5) wait_n = 1'b1;
         e = exp_v(1, 1, 0, 0, 0, 0, 0);
         vecs++;
         if (obs() !== e) begin
            errs++;
            $display("FAIL wait c%0d: got %b want %b", c, obs(), e);
         end
         tick();
      end
      e = exp_v(1, 2, 0, 0, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL wait t2: got %b want %b", obs(), e);
      end
      tick();
      e = exp_v(1, 3, 0, 1, 1, 1, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL wait t3: got %b want %b", obs(), e);
      end
      tick();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL wait idle: busy %b want 0", busy);
      end
   endtask

   task automatic test_chain;
      logic [10:0] e;
      start = 1'b1; mcyc_len = 3'd1; mem_en = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      vecs++;
      if (seq_done !== 1'b1) begin
         errs++;
         $display("FAIL chain sd: got %b want 1", seq_done);
      end
      start = 1'b1; mcyc_len = 3'd0; mem_en = 1'b0;
      tick();
      start = 1'b0; wait_n = 1'b0;
      for (int c = 5; c <= 8; c++) begin
         if (c == 6) begin wait_n = 1'b1; start = 1'b1; end
         if (c == 7) start = 1'b0;
         e = exp_v(1, 2'(c - 5), 0, 1, (c == 8), (c == 8), 0);
         vecs++;
         if (obs() !== e) begin
            errs++;
            $display("FAIL chain c%0d: got %b want %b", c, obs(), e);
         end
         tick();
      end
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL chain idle: busy %b want 0", busy);
      end
   endtask

   task automatic test_halt;
      logic [10:0] e;
      start = 1'b1; mcyc_len = 3'd1; mem_en = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      halt = 1'b1; start = 1'b1;
      tick();
      halt = 1'b0;
      e = exp_v(0, 0, 0, 1, 0, 0, 1);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL halt enter: got %b want %b", obs(), e);
      end
      tick();
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL halt hold: got %b want %b", obs(), e);
      end
      start = 1'b0; wake = 1'b1;
      tick();
      wake = 1'b0;
      e = exp_v(0, 0, 0, 1, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL halt wake: got %b want %b", obs(), e);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      e = exp_v(1, 0, 0, 0, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL halt restart: got %b want %b", obs(), e);
      end
      tick(); tick(); tick();
      vecs++;
      if (seq_done !== 1'b1) begin
         errs++;
         $display("FAIL halt rerun sd: got %b want 1", seq_done);
      end
      tick();
   endtask

   task automatic test_reset_stall;
      logic [10:0] e;
      start = 1'b1; mcyc_len = 3'd2; mem_en = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 6; c++) tick();
      wait_n = 1'b0;
      tick();
      e = exp_v(1, 1, 1, 0, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL stall m1: got %b want %b", obs(), e);
      end
      res = 1'b1;
      tick();
      res = 1'b0; wait_n = 1'b1;
      e = exp_v(0, 0, 0, 1, 0, 0, 0);
      vecs++;
      if (obs() !== e) begin
         errs++;
         $display("FAIL stall reset: got %b want %b", obs(), e);
      end
      tick();
   endtask

   task automatic test_sweep;
      start2 = 1'b1; mcyc_len2 = 2'd3; mem_en = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         vecs++;
         if ({busy2, tstate2, mcyc2, mreq_n2, ld2, sdone2} !==
             {1'b1, 2'((c - 1) % 3), 2'((c - 1) / 3), 1'b0,
              (c % 3 == 0), (c == 9)}) begin
            errs++;
            $display("FAIL sweep c%0d: got %b", c,
               {busy2, tstate2, mcyc2, mreq_n2, ld2, sdone2});
         end
         tick();
      end
      vecs++;
      if (busy2 !== 1'b0) begin
         errs++;
         $display("FAIL sweep idle: busy %b want 0", busy2);
      end
   endtask

   initial begin
      test_reset();
      test_two_mcyc();
      test_wait();
      test_chain();
      test_halt();
      test_reset_stall();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/seq_mcycle_gen.md
# seq_mcycle_gen

Parametrised machine-cycle generator for the sequencer. It divides each instruction into M-cycles of `T_PER_M` T-states and drives the per-T-state timing strobes consumed by the sequencer latches and the memory-request logic. Beyond fixed combinational request decode, it adds:
- variable-length instructions,
- a wait-state stall,
- back-to-back instruction chaining,
- a halt/wake state.

## Interface
Parameters:
- `T_PER_M`, default 4: T-states per M-cycle; legal range ≥2.
- `MCYC_W`, default 3: width of the M-cycle counter and of `mcyc_len`.
- `WAIT_T`, default 1: T-state at which `wait_n` is sampled; legal range 0 ≤ `WAIT_T` < `T_PER_M`-1.
- `MREQ_FIRST`, default 0: first T-state with `mreq_n` low.
- `MREQ_LAST`, default 2: last T-state with `mreq_n` low. Must satisfy `MREQ_FIRST` ≤ `MREQ_LAST` < `T_PER_M`.
- Localparam `TW` = max(1, clog2(`T_PER_M`)).

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `res` in 1: synchronous, active-high reset.
- `start` in 1: begin an instruction; sampled only in IDLE, or in the `seq_done` cycle.
- `mcyc_len` in `MCYC_W`: M-cycles in the instruction; sampled with `start`. A value of 0 is treated as 1.
- `mem_en` in 1: upcoming M-cycle accesses memory. Sampled on every edge that enters T0.
- `wait_n` in 1: active-low wait; sampled on the edge leaving T-state `WAIT_T`.
- `halt` in 1: enter HALT after the current instruction; sampled in the `seq_done` cycle.
- `wake` in 1: leave HALT.
- `tstate` out `TW`: current T-state index.
- `mcyc` out `MCYC_W`: current M-cycle index.
- `busy` out 1: RUN or STALL.
- `mreq_n` out 1: active-low memory request.
- `ld_strobe` out 1: latch-load pulse in the last T-state of each M-cycle.
- `mcyc_done` out 1: same timing as `ld_strobe`.
- `seq_done` out 1: last T-state of the last M-cycle.
- `halted` out 1: in HALT.

## Operation
- States: IDLE, RUN, STALL, HALT.
- All outputs are decoded from registers only (Moore); there is no combinational input-to-output path.
- Registered state: `tstate`, `mcyc`, `len_q`, `mem_en_q`, state.

IDLE:
- `start`=1 → RUN.
- On that edge: `tstate`=0, `mcyc`=0, `len_q`=max(`mcyc_len`,1), `mem_en_q`=`mem_en`.

RUN:
- `tstate` increments on every edge.
- At `tstate`==`WAIT_T` with `wait_n`=0 → STALL, with `tstate` held.
- At `tstate`==`T_PER_M`-1:
  - `tstate` wraps to 0 and `mem_en_q` reloads.
  - If `mcyc`<`len_q`-1, `mcyc` increments.
  - Otherwise the instruction ends. The exit is chosen by priority: `halt`=1 → HALT; else `start`=1 → RUN with `mcyc`=0 and new `len_q`; else → IDLE.

STALL:
- Holds `tstate` and `mcyc`.
- `wait_n`=1 → RUN with `tstate`+1.

HALT:
- `start` is ignored.
- `wake`=1 → IDLE.

Output decode:
- `mreq_n`=0 iff (RUN or STALL) and `mem_en_q` and `MREQ_FIRST` ≤ `tstate` ≤ `MREQ_LAST`; otherwise 1.
- `ld_strobe` = `mcyc_done` = RUN and `tstate`==`T_PER_M`-1.
- `seq_done` = `mcyc_done` and `mcyc`==`len_q`-1.
- `busy` = RUN or STALL.
- `halted` = HALT.

Counter and width rules:
- `tstate` wraps only at `T_PER_M`-1, never at 2^`TW`.
- `mcyc` never exceeds `len_q`-1; a `len_q` of 2^`MCYC_W`-1 is legal.

## Timing
- Reset values: state IDLE, `tstate`=0, `mcyc`=0, `len_q`=1, `mem_en_q`=0, `busy`=0, `mreq_n`=1, `ld_strobe`=0, `mcyc_done`=0, `seq_done`=0, `halted`=0.
- `res` overrides every other input on the same edge. This includes a reset mid-M-cycle, during STALL, or in HALT.
- Start latency: `busy` and T0 appear in the cycle after the `start` edge.
- Instruction length: `len_q`·`T_PER_M` cycles plus stall cycles.
- Wait-state cycle count: T-state `WAIT_T` lasts 1 + N cycles, where N is the number of consecutive edges sampling `wait_n`=0. `mreq_n` holds its value throughout.
- Chaining: `start` asserted in the `seq_done` cycle gives a zero-bubble T0 on the next cycle.
- `start` outside IDLE and outside the `seq_done` cycle is ignored.
- `halt` and `start` in the same `seq_done` cycle: `halt` wins.
- `wait_n` is ignored outside T-state `WAIT_T`, in IDLE, and in HALT.
- HALT exit: one IDLE cycle after `wake` precedes any new `start`.

## Test plan
- Reset: hold `res`=1 for 2 cycles with random inputs → every output at its reset value; `mreq_n`=1.
- Two-M-cycle instruction (defaults): `start`=1, `mcyc_len`=2, `mem_en`=1, `wait_n`=1.
  - `tstate` runs 0,1,2,3,0,1,2,3.
  - `mreq_n` is low for T0–T2 of each M-cycle.
  - `ld_strobe` pulses in cycles 4 and 8; `seq_done` only in cycle 8.
  - Then IDLE: `busy`=0.
- Wait stall: `wait_n`=0 for 3 edges at T1 → T1 lasts 4 cycles, the M-cycle takes 7 cycles, `mreq_n` stays low throughout, and `mcyc` is unchanged.
- Chaining with zero length: `start` in the `seq_done` cycle with `mcyc_len`=0 → the next cycle is T0 with `mcyc`=0, `busy` never drops, and the instruction lasts 4 cycles. With `mem_en`=0 sampled, `mreq_n` stays 1.
- Halt: `halt`=1 and `start`=1 in the `seq_done` cycle → `halted`=1 and a later `start` is ignored. `wake`=1 → IDLE next cycle, after which `start` runs normally.
- Reset during STALL at `mcyc`=1 → next cycle all reset values, `mreq_n`=1.
- Parameter sweep: `T_PER_M`=3, `MCYC_W`=2, `MCYC_LEN`=3 → `tstate` wraps at 2 and `seq_done` occurs in cycle 9.
